tdm_serializer_2ch: RTL and testbench
=====================================

# tdm_serializer_2ch

Two-channel time-division serializer feeding the 2:1 bit multiplexer. Each channel accepts a parallel word over a valid/ready handshake and double-buffers it. Once both channels hold a word, the block shifts them out MSB-first. It drives the mux data pair and select so that the mux output carries the two channels interleaved bit by bit, with a frame marker on the first slot.

## Interface
- WIDTH, 8, bits per channel word (≥2)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- d0  in  WIDTH  channel 0 word
- v0  in  1  channel 0 valid
- r0  out  1  channel 0 ready
- d1  in  WIDTH  channel 1 word
- v1  in  1  channel 1 valid
- r1  out  1  channel 1 ready
- mux_i  out  2  current bit of each lane: [0]=ch0, [1]=ch1 (drives mux data input)
- mux_s  out  1  mux select: 0 = ch0 slot, 1 = ch1 slot
- frame  out  1  high during slot 0 of every frame
- busy  out  1  high while in SHIFT

## Operation
- Per lane: holding register with full flag, plus shift register. rN = ~holdN_full. Accept on rising edge when vN & rN; the hold becomes full.
- FSM states:
  - IDLE: all outputs 0. When hold0_full & hold1_full, copy both holds into the shift registers, clear both full flags, clear the slot counter, go to SHIFT.
  - SHIFT: slot counter k runs 0..L-1, where L = 2*WIDTH (2*(WIDTH+1) with parity).
- Slot outputs:
  - mux_s = k[0].
  - mux_i[n] = MSB of lane n shift register.
  - frame = (k==0).
  - Shift registers shift left by one (zero fill) at the end of each odd slot.
- Last slot (k==L-1):
  - If both holds are full, reload as in IDLE, set k=0 and stay in SHIFT. This gives back-to-back frames with no gap.
  - Otherwise go to IDLE.
- A lane that fills while the other is empty simply waits; no partial frames are sent.
- Downstream mux output y therefore reads: ch0 b[W-1], ch1 b[W-1], ch0 b[W-2], …

## Timing
- Word accepted at edge E. The transfer edge is E+1 if the other hold is already full. Slot 0 is visible after E+1, so latency is 2 cycles from the accept edge.
- Frame length is L cycles. Throughput is one word per lane per L cycles.
- rN goes high again the cycle after transfer. A new word can be accepted during the remainder of the frame.
- The transfer edge and the accept edge never coincide on a lane, because ready is low while the hold is full.
- Reset values: r0=r1=1; mux_i=0, mux_s=0, frame=0, busy=0; state IDLE, k=0, holds empty.
- rst asserted mid-frame abandons the frame and drops both holds. Outputs take their reset values on the next edge.

## Configuration
- TDM_PARITY_EN defined:
  - Each lane appends an even-parity bit over its WIDTH data bits, computed at transfer.
  - The parity bits occupy slots 2W (ch0) and 2W+1 (ch1); L = 2W+2.
- TDM_PARITY_EN undefined: no parity logic; L = 2W.

## Structure
- Package tdm_pkg holds:
  - default WIDTH
  - FSM state enum (IDLE, SHIFT)
  - slot-count function L(WIDTH) and counter width $clog2(L)
- Sub-module tdm_lane (hold register, full flag, shift register, optional parity), instantiated twice. The FSM and slot counter live in the top.

## Test plan
- Reset, then idle → r0=r1=1; mux_i=0, mux_s=0, frame=0, busy=0.
- d0=8'hA5, d1=8'h3C accepted in the same cycle → slot 0 two cycles later with frame=1. mux_s alternates 0,1. The muxed bit sequence is 1,0,0,0,1,1,0,1,0,1,1,1,0,0,1,0; busy drops after 16 slots.
- d0=8'hFF loaded, d1 withheld 10 cycles → no frame starts and r0=0 throughout. Slot 0 appears 2 cycles after d1 is accepted.
- Next pair (8'h00, 8'hFF) loaded mid-frame → second frame's slot 0 immediately follows slot 15 with frame=1 and no idle cycle.
- TDM_PARITY_EN with d0=8'hA5, d1=8'h01 → L=18. Slot 16 bit = 0 and slot 17 bit = 1.
- rst pulsed at slot 5 → next cycle all outputs 0 and r0=r1=1. The following frame reproduces a fresh transfer correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the two-channel TDM serializer.
// Define TDM_PARITY_EN to append an even-parity slot per lane to every frame.
package tdm_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_e;

   // Slots per frame: two lanes interleaved, plus one parity slot per lane when enabled.
   function automatic int unsigned slot_count(input int unsigned width);
`ifdef TDM_PARITY_EN
      return 2 * (width + 1);
`else
      return 2 * width;
`endif
   endfunction

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(slot_count(width));
   endfunction

endpackage

// File: rtl/tdm_lane.sv
// One serializer lane: holding register with full flag feeding an MSB-first shift register.
// Under TDM_PARITY_EN an even-parity bit is appended below the data at transfer.
module tdm_lane
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             v,
   output logic             r,
   input  logic             load,
   input  logic             shift,
   output logic             full,
   output logic             msb
);

`ifdef TDM_PARITY_EN
   localparam int unsigned SregW = WIDTH + 1;
`else
   localparam int unsigned SregW = WIDTH;
`endif

   logic [WIDTH-1:0] hold_q;
   logic             full_q;
   logic [SregW-1:0] sreg_q;
   logic [SregW-1:0] load_val;

   always_comb begin
`ifdef TDM_PARITY_EN
      load_val = {hold_q, ^hold_q};
`else
      load_val = hold_q;
`endif
   end

   // Accept and transfer never coincide: transfer needs full, accept needs empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else if (load) begin
         full_q <= 1'b0;
      end else if (v && !full_q) begin
         hold_q <= d;
         full_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q <= '0;
      end else if (load) begin
         sreg_q <= load_val;
      end else if (shift) begin
         sreg_q <= {sreg_q[SregW-2:0], 1'b0};
      end
   end

   assign r    = ~full_q;
   assign full = full_q;
   assign msb  = sreg_q[SregW-1];

endmodule

// File: rtl/tdm_serializer_2ch.sv
// Two-channel TDM serializer: frames both lanes bit-interleaved onto a 2:1 mux.
// Build with TDM_PARITY_EN to add a trailing even-parity slot pair per frame.
module tdm_serializer_2ch
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d0,
   input  logic             v0,
   output logic             r0,
   input  logic [WIDTH-1:0] d1,
   input  logic             v1,
   output logic             r1,
   output logic [1:0]       mux_i,
   output logic             mux_s,
   output logic             frame,
   output logic             busy
);

   localparam int unsigned     SlotCount = slot_count(WIDTH);
   localparam int unsigned     CntW      = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastSlot  = CntW'(SlotCount - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] k_q, k_d;
   logic            load, shift;
   logic            full0, full1;
   logic            msb0, msb1;

   tdm_lane #(
      .WIDTH(WIDTH)
   ) u_lane0 (
      .clk  (clk),
      .rst  (rst),
      .d    (d0),
      .v    (v0),
      .r    (r0),
      .load (load),
      .shift(shift),
      .full (full0),
      .msb  (msb0)
   );

   tdm_lane #(
      .WIDTH(WIDTH)
   ) u_lane1 (
      .clk  (clk),
      .rst  (rst),
      .d    (d1),
      .v    (v1),
      .r    (r1),
      .load (load),
      .shift(shift),
      .full (full1),
      .msb  (msb1)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      load    = 1'b0;
      shift   = 1'b0;
      mux_i   = '0;
      mux_s   = 1'b0;
      frame   = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (full0 && full1) begin
               load    = 1'b1;
               k_d     = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            busy  = 1'b1;
            mux_s = k_q[0];
            mux_i = {msb1, msb0};
            frame = (k_q == '0);
            // Both lanes advance after the ch1 slot; a reload on the last slot overrides.
            shift = k_q[0];
            if (k_q == LastSlot) begin
               k_d = '0;
               if (full0 && full1) begin
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               k_d = k_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

endmodule

// File: tb/tb_tdm_serializer_2ch.sv
// Scoreboard bench for tdm_serializer_2ch: expected slots queued at stimulus, checked by a monitor.
module tb_tdm_serializer_2ch;

   localparam int unsigned W = 8;
`ifdef TDM_PARITY_EN
   localparam int unsigned L = 2 * W + 2;
`else
   localparam int unsigned L = 2 * W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] d0 = '0, d1 = '0;
   logic         v0 = 1'b0, v1 = 1'b0;
   logic         r0, r1;
   logic [1:0]   mux_i;
   logic         mux_s, frame, busy;

   typedef struct packed {
      logic y;
      logic s;
      logic f;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   tdm_serializer_2ch #(
      .WIDTH(W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .d0   (d0),
      .v0   (v0),
      .r0   (r0),
      .d1   (d1),
      .v1   (v1),
      .r1   (r1),
      .mux_i(mux_i),
      .mux_s(mux_s),
      .frame(frame),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: ch0/ch1 bits MSB-first interleaved, then optional even-parity bits.
   task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = W - 1; i >= 0; i--) begin
         q.push_back('{y: a[i], s: 1'b0, f: (i == W - 1)});
         q.push_back('{y: b[i], s: 1'b1, f: 1'b0});
      end
`ifdef TDM_PARITY_EN
      q.push_back('{y: ^a, s: 1'b0, f: 1'b0});
      q.push_back('{y: ^b, s: 1'b1, f: 1'b0});
`endif
   endtask

   // Hand-computed stream for A5/3C (parity of both words is 0).
   task automatic push_a5_3c();
      logic [15:0] seq;
      seq = 16'b1000_1101_0111_0010;
      for (int i = 15; i >= 0; i--) begin
         q.push_back('{y: seq[i], s: i[0] ? 1'b0 : 1'b1, f: (i == 15)});
      end
`ifdef TDM_PARITY_EN
      q.push_back('{y: 1'b0, s: 1'b0, f: 1'b0});
      q.push_back('{y: 1'b0, s: 1'b1, f: 1'b0});
`endif
   endtask

   task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
      check("ready_before_send", {r0, r1}, 2'b11);
      d0 = a;
      d1 = b;
      v0 = 1'b1;
      v1 = 1'b1;
      tick();
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 0 && busy === 1'b0) break;
         tick();
      end
      check("drained_idle", {q.size() == 0, busy}, 2'b10);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_slot: busy=1 frame=%0b but no slot expected at %0t",
                     frame, $time);
         end else begin
            e = q.pop_front();
            check("slot_bit", mux_i[mux_s], e.y);
            check("slot_sel", mux_s, e.s);
            check("slot_frame", frame, e.f);
         end
      end
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_ready", {r0, r1}, 2'b11);
      check("reset_outputs", {mux_i, mux_s, frame, busy}, 5'b0);

      // Simultaneous accept; slot 0 two edges after acceptance, frame is exactly L slots.
      push_a5_3c();
      send_pair(8'hA5, 8'h3C);
      check("t1_not_yet_busy", busy, 1'b0);
      tick();
      check("t1_slot0", {busy, frame}, 2'b11);
      repeat (L - 1) tick();
      check("t1_last_slot_busy", busy, 1'b1);
      tick();
      check("t1_busy_dropped", busy, 1'b0);
      wait_idle();

      // Ch0 waits alone: no partial frame.
      d0 = 8'hFF;
      v0 = 1'b1;
      tick();
      v0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("t2_r0_low", r0, 1'b0);
         check("t2_no_frame", busy, 1'b0);
         tick();
      end
      push_pair(8'hFF, 8'h81);
      check("t2_r1_high", r1, 1'b1);
      d1 = 8'h81;
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      check("t2_not_yet_busy", busy, 1'b0);
      tick();
      check("t2_slot0", {busy, frame}, 2'b11);
      check("t2_ready_after_transfer", {r0, r1}, 2'b11);

      // Next pair loaded mid-frame: frames run back to back.
      tick();
      tick();
      push_pair(8'h00, 8'hFF);
      send_pair(8'h00, 8'hFF);
      repeat (L - 4) tick();
      check("t3_last_slot", {busy, frame, mux_s}, 3'b101);
      tick();
      check("t3_next_frame_no_gap", {busy, frame}, 2'b11);
      wait_idle();

      // Parity-sensitive pair (parity bits 0 then 1 when enabled).
      push_pair(8'hA5, 8'h01);
      send_pair(8'hA5, 8'h01);
      wait_idle();

      // Reset mid-frame at slot 5 abandons the frame.
      push_pair(8'h5A, 8'hC3);
      send_pair(8'h5A, 8'hC3);
      tick();
      check("t4_slot0", frame, 1'b1);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      q.delete();
      check("t4_reset_outputs", {mux_i, mux_s, frame, busy}, 5'b0);
      check("t4_reset_ready", {r0, r1}, 2'b11);
      rst = 1'b0;
      tick();

      push_a5_3c();
      send_pair(8'hA5, 8'h3C);
      tick();
      check("t4_fresh_slot0", {busy, frame}, 2'b11);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
